xgmii_rate_match_rd_ctrl: RTL and testbench



---
 rtl/xgmii_rate_match_rd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_xgmii_rate_match_rd_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rate_match_rd_ctrl.sv
// Read-side sequencer for the XGMII retransmit FIFO: pre-fill, idle insertion in the IPG, underrun -> Local Fault.
// Word layout {ena, ctrl[3:0], data[31:0]}; optional statistics counters under `XGMII_RMC_STATS_EN.
module xgmii_rate_match_rd_ctrl #(
    parameter int LVL_W     = 6,
    parameter int START_LVL = 16,
    parameter int LO_WM     = 8,
    parameter int INS_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic             fifo_empty,
    input  logic [36:0]      fifo_q,
    output logic             fifo_rd,
    output logic [36:0]      tx,
    output logic             underrun,
    output logic [15:0]      ins_cnt,
    output logic [15:0]      urun_cnt
);

    localparam logic [36:0] IDLE_W = {1'b1, 4'hF, 32'h07070707};
    localparam logic [36:0] LF_W   = {1'b1, 4'h1, 32'h0100009C};

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [36:0] tx_r, tx_s;
    logic        underrun_r, underrun_s;
    logic        in_frame_r, in_frame_s;
    logic [3:0]  gap_r, gap_s;
    logic [1:0]  fault_cnt_r, fault_cnt_s;
    logic        rd_s, pop_s, ins_ok_s;

    function automatic logic is_start(input logic [36:0] w);
        return w[36] && w[32] && (w[7:0] == 8'hFB);
    endfunction

    function automatic logic is_term(input logic [36:0] w);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = t | (w[32+i] && (w[8*i +: 8] == 8'hFD));
        end
        return w[36] && t;
    endfunction

    // Insertion only in the gap: out of frame, behind an IDLE, with enough pops since the last one.
    assign ins_ok_s = (fifo_level < LVL_W'(LO_WM)) && !in_frame_r &&
                      (tx_r == IDLE_W) && (gap_r >= 4'(INS_GAP));
    assign fifo_rd  = rd_s;
    assign tx       = tx_r;
    assign underrun = underrun_r;

    // Next-state, pop strobe and next output word.
    always_comb begin
        state_s     = state_r;
        tx_s        = tx_r;
        underrun_s  = 1'b0;
        in_frame_s  = in_frame_r;
        gap_s       = gap_r;
        fault_cnt_s = fault_cnt_r;
        pop_s       = 1'b0;
        rd_s        = 1'b0;
        case (state_r)
            ST_FILL: begin
                tx_s = IDLE_W;
                if (fifo_level >= LVL_W'(START_LVL)) begin
                    state_s = ST_RUN;
                    pop_s   = !fifo_empty;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (ins_ok_s) begin
                    tx_s  = IDLE_W;
                    gap_s = 4'd0;
                end else if (fifo_empty) begin
                    tx_s        = LF_W;
                    underrun_s  = 1'b1;
                    in_frame_s  = 1'b0;
                    fault_cnt_s = 2'd0;
                    state_s     = ST_FAULT;
                end else begin
                    pop_s = 1'b1;
                end
            end
            ST_FAULT: begin
                tx_s = LF_W;
                if (fault_cnt_r == 2'd3) begin
                    state_s = ST_FILL;
                    tx_s    = IDLE_W;
                end else begin
                    fault_cnt_s = fault_cnt_r + 2'd1;
                end
            end
            default: begin
                state_s = ST_FILL;
                tx_s    = IDLE_W;
            end
        endcase
        // A popped word is forwarded as-is; only valid control words move the frame tracker.
        if (pop_s) begin
            rd_s  = 1'b1;
            tx_s  = fifo_q;
            gap_s = (gap_r == 4'd15) ? 4'd15 : gap_r + 4'd1;
            if (is_term(fifo_q)) begin
                in_frame_s = 1'b0;
            end else if (is_start(fifo_q)) begin
                in_frame_s = 1'b1;
            end else begin
                in_frame_s = in_frame_r;
            end
        end else begin
            rd_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FILL;
            tx_r        <= IDLE_W;
            underrun_r  <= 1'b0;
            in_frame_r  <= 1'b0;
            gap_r       <= 4'(INS_GAP);
            fault_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            tx_r        <= tx_s;
            underrun_r  <= underrun_s;
            in_frame_r  <= in_frame_s;
            gap_r       <= gap_s;
            fault_cnt_r <= fault_cnt_s;
        end
    end

`ifdef XGMII_RMC_STATS_EN
    logic [15:0] ins_cnt_r, urun_cnt_r;

    // Saturating insertion / underrun statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_cnt_r  <= 16'd0;
            urun_cnt_r <= 16'd0;
        end else begin
            if ((state_r == ST_RUN) && ins_ok_s && (ins_cnt_r != 16'hFFFF)) begin
                ins_cnt_r <= ins_cnt_r + 16'd1;
            end
            if (underrun_s && (urun_cnt_r != 16'hFFFF)) begin
                urun_cnt_r <= urun_cnt_r + 16'd1;
            end
        end
    end

    assign ins_cnt  = ins_cnt_r;
    assign urun_cnt = urun_cnt_r;
`else
    assign ins_cnt  = 16'd0;
    assign urun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_xgmii_rate_match_rd_ctrl.sv
// Bench for xgmii_rate_match_rd_ctrl: cycle-level reference model plus directed scenarios with literal pins.
// Counter expectations follow `XGMII_RMC_STATS_EN.
module tb_xgmii_rate_match_rd_ctrl;

    localparam logic [36:0] IDLE_W  = {1'b1, 4'hF, 32'h07070707};
    localparam logic [36:0] LF_W    = {1'b1, 4'h1, 32'h0100009C};
    localparam logic [36:0] START_W = {1'b1, 4'h1, 32'h555555FB};
    localparam logic [36:0] TERM_W  = {1'b1, 4'hE, 32'h0707FDAA};
`ifdef XGMII_RMC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst;
    logic [5:0]  fifo_level;
    logic        fifo_empty;
    logic [36:0] fifo_q;
    logic        fifo_rd;
    logic [36:0] tx;
    logic        underrun;
    logic [15:0] ins_cnt, urun_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit armed = 1'b0;

    xgmii_rate_match_rd_ctrl dut (
        .clk(clk), .rst(rst), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_rd(fifo_rd), .tx(tx), .underrun(underrun),
        .ins_cnt(ins_cnt), .urun_cnt(urun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [36:0] dw(input logic [31:0] d);
        return {1'b1, 4'h0, d};
    endfunction

    // Reference model: mode 0=fill, 1=run, 2=fault; lf_left = LF words still owed after the current one.
    int          m_mode = 0;
    logic [36:0] m_tx = IDLE_W;
    bit          m_urun = 1'b0;
    int          m_gap = 4;
    bit          m_inf = 1'b0;
    int          m_lf_left = 0;
    int          m_ins = 0;
    int          m_urn = 0;

    always @(negedge clk) begin
        bit ins_ok, pop, st, te;
        ins_ok = (m_mode == 1) && (fifo_level < 6'd8) && !m_inf && (m_tx == IDLE_W) && (m_gap >= 4);
        pop = (m_mode == 0) ? (fifo_level >= 6'd16 && !fifo_empty)
            : (m_mode == 1) ? (!ins_ok && !fifo_empty) : 1'b0;
        if (armed) begin
            chk("fifo_rd", {63'd0, fifo_rd}, {63'd0, pop});
            chk("tx", {27'd0, tx}, {27'd0, m_tx});
            chk("underrun", {63'd0, underrun}, {63'd0, m_urun});
            chk("ins_cnt", {48'd0, ins_cnt}, STATS ? 64'(m_ins) : 64'd0);
            chk("urun_cnt", {48'd0, urun_cnt}, STATS ? 64'(m_urn) : 64'd0);
        end
        if (rst) begin
            m_mode = 0; m_tx = IDLE_W; m_urun = 1'b0; m_gap = 4; m_inf = 1'b0;
            m_ins = 0; m_urn = 0;
        end else begin
            m_urun = 1'b0;
            if (m_mode == 0) begin
                m_tx = IDLE_W;
                if (fifo_level >= 6'd16) m_mode = 1;
            end else if (m_mode == 1) begin
                if (ins_ok) begin
                    m_tx = IDLE_W; m_gap = 0; m_ins = (m_ins < 65535) ? m_ins + 1 : m_ins;
                end else if (fifo_empty) begin
                    m_tx = LF_W; m_urun = 1'b1; m_mode = 2; m_lf_left = 3; m_inf = 1'b0;
                    m_urn = (m_urn < 65535) ? m_urn + 1 : m_urn;
                end
            end else begin
                if (m_lf_left == 0) begin
                    m_mode = 0; m_tx = IDLE_W;
                end else begin
                    m_lf_left--;
                end
            end
            if (pop) begin
                m_tx = fifo_q;
                m_gap = (m_gap < 15) ? m_gap + 1 : 15;
                st = fifo_q[36] && fifo_q[32] && (fifo_q[7:0] == 8'hFB);
                te = 1'b0;
                for (int i = 0; i < 4; i++)
                    if (fifo_q[36] && fifo_q[32+i] && (fifo_q[8*i +: 8] == 8'hFD)) te = 1'b1;
                if (te) m_inf = 1'b0;
                else if (st) m_inf = 1'b1;
            end
        end
    end

    task automatic go(input int lvl, input logic emp, input logic [36:0] q);
        fifo_level = 6'(lvl);
        fifo_empty = emp;
        fifo_q     = q;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int lvl, input logic emp, input logic [36:0] q);
        go(lvl, emp, q);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        go(0, 1'b1, 37'd0); tick();
        armed = 1'b1;
        go(0, 1'b1, 37'd0);
        chk("rst_tx", {27'd0, tx}, {27'd0, IDLE_W});
        chk("rst_rd", {63'd0, fifo_rd}, 64'd0);
        chk("rst_underrun", {63'd0, underrun}, 64'd0);
        tick();
        rst = 1'b0;

        // Pre-fill: level 15 holds, level 16 pops immediately.
        for (int i = 0; i < 3; i++) begin
            go(15, 1'b0, dw(32'h1));
            chk("fill15_rd", {63'd0, fifo_rd}, 64'd0);
            chk("fill15_tx", {27'd0, tx}, {27'd0, IDLE_W});
            tick();
        end
        go(16, 1'b0, dw(32'hA1));
        chk("fill16_rd", {63'd0, fifo_rd}, 64'd1);
        tick();

        // Frame then gap at low level: one insertion, next only after 4 pops.
        go(7, 1'b0, START_W);
        chk("first_word", {27'd0, tx}, {27'd0, dw(32'hA1)});
        tick();
        step(7, 1'b0, dw(32'hD0));
        step(7, 1'b0, dw(32'hD1));
        step(7, 1'b0, TERM_W);
        go(7, 1'b0, IDLE_W);
        chk("after_term_rd", {63'd0, fifo_rd}, 64'd1);
        tick();
        go(7, 1'b0, IDLE_W);
        chk("ins1_rd", {63'd0, fifo_rd}, 64'd0);
        tick();
        go(7, 1'b0, IDLE_W);
        chk("ins1_tx", {27'd0, tx}, {27'd0, IDLE_W});
        chk("ins1_cnt", {48'd0, ins_cnt}, STATS ? 64'd1 : 64'd0);
        chk("gap0_rd", {63'd0, fifo_rd}, 64'd1);
        tick();
        for (int i = 0; i < 3; i++) step(7, 1'b0, IDLE_W);
        go(7, 1'b0, IDLE_W);
        chk("ins2_rd", {63'd0, fifo_rd}, 64'd0);
        tick();

        // Insertion beats underrun, then the empty FIFO faults.
        for (int i = 0; i < 4; i++) step(20, 1'b0, IDLE_W);
        go(0, 1'b1, IDLE_W);
        chk("ins_vs_urun_rd", {63'd0, fifo_rd}, 64'd0);
        tick();
        go(0, 1'b1, IDLE_W);
        chk("ins_vs_urun_tx", {27'd0, tx}, {27'd0, IDLE_W});
        chk("ins_vs_urun_pulse", {63'd0, underrun}, 64'd0);
        tick();
        go(0, 1'b1, IDLE_W);
        chk("urun1_tx", {27'd0, tx}, {27'd0, 37'h1_1_0100009C});
        chk("urun1_pulse", {63'd0, underrun}, 64'd1);
        chk("urun1_cnt", {48'd0, urun_cnt}, STATS ? 64'd1 : 64'd0);
        chk("ins3_cnt", {48'd0, ins_cnt}, STATS ? 64'd3 : 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            go(0, 1'b1, IDLE_W);
            chk("fault_lf", {27'd0, tx}, {27'd0, LF_W});
            chk("fault_pulse", {63'd0, underrun}, 64'd0);
            tick();
        end
        go(5, 1'b1, IDLE_W);
        chk("fault_exit_tx", {27'd0, tx}, {27'd0, IDLE_W});
        tick();

        // Low level inside a frame: no insertion, then underrun truncates the frame.
        go(16, 1'b0, dw(32'hB1));
        chk("refill_rd", {63'd0, fifo_rd}, 64'd1);
        tick();
        step(5, 1'b0, START_W);
        for (int i = 0; i < 3; i++) begin
            go(5, 1'b0, dw(32'hC0 + 32'(i)));
            chk("inframe_rd", {63'd0, fifo_rd}, 64'd1);
            tick();
        end
        go(5, 1'b1, IDLE_W);
        chk("inframe_empty_rd", {63'd0, fifo_rd}, 64'd0);
        tick();
        go(5, 1'b1, IDLE_W);
        chk("urun2_tx", {27'd0, tx}, {27'd0, LF_W});
        chk("urun2_pulse", {63'd0, underrun}, 64'd1);
        chk("urun2_cnt", {48'd0, urun_cnt}, STATS ? 64'd2 : 64'd0);
        tick();
        for (int i = 0; i < 4; i++) step(5, 1'b1, IDLE_W);

        // Reset in the middle of a frame.
        step(16, 1'b0, dw(32'hE1));
        step(16, 1'b0, START_W);
        step(16, 1'b0, dw(32'hE2));
        rst = 1'b1;
        step(16, 1'b0, dw(32'hE3));
        rst = 1'b0;
        go(10, 1'b0, dw(32'hE4));
        chk("midrst_tx", {27'd0, tx}, {27'd0, IDLE_W});
        chk("midrst_rd", {63'd0, fifo_rd}, 64'd0);
        chk("midrst_ins", {48'd0, ins_cnt}, 64'd0);
        chk("midrst_urun", {48'd0, urun_cnt}, 64'd0);
        tick();
        step(10, 1'b0, dw(32'hE5));
        step(10, 1'b0, dw(32'hE6));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
